// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one pipelined signed Q-format multiplier
// among NUM_REQ requesters; results return with a one-hot tag after PIPE_STAGES cycles.
module mul_share_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int FRAC_BITS   = 10,
   parameter int PIPE_STAGES = 2
) (
   input  logic                          clock_i,
   input  logic                          reset_n_i,
   input  logic                          enable_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
   output logic [NUM_REQ-1:0]            resp_valid_o,
   output logic [DATA_WIDTH-1:0]         resp_data_o,
   output logic                          idle_o,
   output logic [15:0]                   op_count_o
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int PW = 2 * DATA_WIDTH;

   logic [IW-1:0]                ptr_q, ptr_d, gidx;
   logic [IW:0]                  sum;
   logic [NUM_REQ-1:0]           rot;
   logic                         hit, acc;
   logic signed [DATA_WIDTH-1:0] a_q, b_q, res;
   logic [15:0]                  cnt_q;
   // one-hot requester id per stage; all-zero marks an empty stage
   logic [NUM_REQ-1:0]           id_q [PIPE_STAGES];
   logic [DATA_WIDTH-1:0]        r_q [1:PIPE_STAGES-1];

   // rotate so bit k is requester (ptr + k) mod NUM_REQ; the lowest set bit wins
   always_comb begin
      rot = NUM_REQ'({req_valid_i, req_valid_i} >> ptr_q);
      hit = 1'b0;
      sum = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (rot[k]) begin
            hit = 1'b1;
            sum = {1'b0, ptr_q} + (IW+1)'(k);
         end
      gidx = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ)) : IW'(sum);
      req_ready_o = (hit && enable_i) ? (NUM_REQ'(1) << gidx) : '0;
      acc = |req_ready_o;
      ptr_d = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
   end

   assign res = DATA_WIDTH'((PW'(a_q) * PW'(b_q)) >>> FRAC_BITS);

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ptr_q <= '0;
         cnt_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         for (int k = 0; k < PIPE_STAGES; k++) id_q[k] <= '0;
         for (int k = 1; k < PIPE_STAGES; k++) r_q[k] <= '0;
      end else begin
         if (acc) begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_q + 1'b1;
            a_q   <= req_a_i[gidx*DATA_WIDTH +: DATA_WIDTH];
            b_q   <= req_b_i[gidx*DATA_WIDTH +: DATA_WIDTH];
         end
         id_q[0] <= req_ready_o;
         for (int k = 1; k < PIPE_STAGES; k++) id_q[k] <= id_q[k-1];
         if (|id_q[0]) r_q[1] <= res;
         for (int k = 2; k < PIPE_STAGES; k++)
            if (|id_q[k-1]) r_q[k] <= r_q[k-1];
      end
   end

   always_comb begin
      idle_o = 1'b1;
      for (int k = 0; k < PIPE_STAGES; k++) idle_o = idle_o & ~|id_q[k];
   end

   assign resp_valid_o = id_q[PIPE_STAGES-1];
   assign resp_data_o  = r_q[PIPE_STAGES-1];
   assign op_count_o   = cnt_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a queue-based model of grants, latency and Q10 products.
module tb_mul_share_arbiter;
   localparam int N = 4, W = 32, F = 10, P = 2;

   logic           clk = 1'b0, rst_n = 1'b1, en = 1'b0;
   logic [N-1:0]   rv, rdy, rsp_v, hold;
   logic [W-1:0]   oa [N], ob [N];
   logic [N*W-1:0] pa, pb;
   logic [W-1:0]   rsp_d;
   logic           idle;
   logic [15:0]    opc;
   int             total = 0, bad = 0;

   typedef struct { int due; int id; logic [W-1:0] data; } ent_t;
   ent_t        q[$];
   int          glog[$];
   int          ptr = 0, cyc = 0;
   logic [15:0] cnt = '0;
   logic [W-1:0] last = '0;

   always #5 clk = ~clk;

   for (genvar i = 0; i < N; i++) begin : g_pk
      assign pa[i*W +: W] = oa[i];
      assign pb[i*W +: W] = ob[i];
   end

   mul_share_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .FRAC_BITS(F), .PIPE_STAGES(P)) dut (
      .clock_i(clk), .reset_n_i(rst_n), .enable_i(en), .req_valid_i(rv), .req_ready_o(rdy),
      .req_a_i(pa), .req_b_i(pb), .resp_valid_o(rsp_v), .resp_data_o(rsp_d),
      .idle_o(idle), .op_count_o(opc));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] mulq(input logic [W-1:0] a, input logic [W-1:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return W'(p >>> F);
   endfunction

   function automatic logic [W-1:0] rnd_op();
      case ($urandom_range(0, 3))
         0: return W'($urandom());
         1: return W'($urandom_range(0, 8191)) - W'(4096);
         2: return $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
         default: return $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'd1024;
      endcase
   endfunction

   task automatic model_reset();
      q.delete();
      ptr  = 0;
      cnt  = '0;
      last = '0;
   endtask

   // one clock: check all outputs at the falling edge, then advance the model at the rising edge
   task automatic step();
      int g;
      logic [N-1:0] rv_e;
      ent_t e;
      @(negedge clk);
      g = -1;
      if (en)
         for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (g < 0 && rv[j]) g = j;
         end
      chk("ready", rdy, (g >= 0) ? (64'd1 << g) : 64'd0);
      chk("idle", idle, 64'(q.size() == 0));
      rv_e = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
         rv_e = N'(1) << q[0].id;
         last = q[0].data;
         void'(q.pop_front());
      end
      chk("resp_valid", rsp_v, rv_e);
      chk("resp_data", rsp_d, last);
      chk("op_count", opc, cnt);
      @(posedge clk);
      if (g >= 0) begin
         e.due  = cyc + P;
         e.id   = g;
         e.data = mulq(oa[g], ob[g]);
         q.push_back(e);
         glog.push_back(g);
         ptr = (g + 1) % N;
         cnt = cnt + 16'd1;
      end
      cyc++;
      #1;
   endtask

   task automatic one(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] exp_d, input string tag);
      rv = '0;
      rv[id] = 1'b1;
      oa[id] = a;
      ob[id] = b;
      step();
      rv = '0;
      repeat (P - 1) step();
      chk({tag, "_rv"}, rsp_v, N'(1) << id);
      chk({tag, "_rd"}, rsp_d, exp_d);
      step();
      chk({tag, "_idle"}, idle, 1);
   endtask

   initial begin
      rv = '0;
      en = 1'b1;
      hold = '0;
      for (int i = 0; i < N; i++) begin
         oa[i] = '0;
         ob[i] = '0;
      end
      #1 rst_n = 1'b0;
      #1;
      chk("rst_rv", rsp_v, 0);
      chk("rst_rd", rsp_d, 0);
      chk("rst_idle", idle, 1);
      chk("rst_cnt", opc, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      one(0, 32'd1024, 32'd1024, 32'd1024, "basic");
      chk("basic_cnt", opc, 1);
      one(0, W'(-1536), 32'd2048, 32'hFFFF_F400, "neg");
      one(0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, "floor");

      glog.delete();
      rv = 4'b0100;
      step();
      rv = 4'b1010;
      step();
      rv = 4'b0010;
      step();
      rv = '0;
      repeat (P) step();
      chk("fair_n", glog.size(), 3);
      chk("fair_first", (glog.size() > 1) ? glog[1] : -1, 3);
      chk("fair_second", (glog.size() > 2) ? glog[2] : -1, 1);

      rv = 4'b0001;
      step();
      rv = 4'b0100;
      step();
      en = 1'b0;
      rv = 4'b0010;
      #1 chk("en_rdy0", rdy, 0);
      repeat (P) step();
      chk("en_idle", idle, 1);
      en = 1'b1;
      #1 chk("en_rdy1", rdy, 4'b0010);
      glog.delete();
      step();
      rv = '0;
      chk("en_gnt", (glog.size() == 1) ? glog[0] : -1, 1);
      repeat (P) step();

      rv = 4'b0001;
      step();
      rv = '0;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_rv", rsp_v, 0);
      chk("mid_rst_cnt", opc, 0);
      chk("mid_rst_idle", idle, 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) step();

      glog.delete();
      rv = 4'b1111;
      repeat (8) step();
      chk("rr_cnt", opc, 8);
      chk("rr_n", glog.size(), 8);
      for (int k = 0; k < glog.size() && k < 8; k++) chk("rr_order", glog[k], k % N);
      rv = '0;
      repeat (P + 1) step();

      repeat (500) begin
         for (int i = 0; i < N; i++) begin
            if (!hold[i] && $urandom_range(0, 1) == 1) begin
               hold[i] = 1'b1;
               oa[i] = rnd_op();
               ob[i] = rnd_op();
            end else if (hold[i] && $urandom_range(0, 15) == 0) begin
               hold[i] = 1'b0;
            end
         end
         rv = hold;
         en = ($urandom_range(0, 7) != 0);
         glog.delete();
         step();
         if (glog.size() > 0) hold[glog[0]] = 1'b0;
      end
      en = 1'b1;
      rv = '0;
      repeat (P + 1) step();
      chk("final_idle", idle, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
